// File: rtl/dram_wb_pkg.sv
// Shared types and width helpers for the DRAM Wishbone width adapter.
// The optional line buffer is enabled by defining DRAM_WB_LINE_BUFFER_EN.
package dram_wb_pkg;

  localparam int HDW = 32;
  localparam int DDW = 256;
  localparam int DAW = 25;
  localparam int HAW = 32;

  function automatic int ofs_w(input int ddw);
    return $clog2(ddw / 8);
  endfunction

  function automatic int lsb_w(input int hdw);
    return $clog2(hdw / 8);
  endfunction

  function automatic int lane_w(input int hdw, input int ddw);
    return (ddw > hdw) ? $clog2(ddw / hdw) : 1;
  endfunction

  localparam int LNW = lane_w(HDW, DDW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAM_REQ,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic             we;
    logic [DAW-1:0]   line;
    logic [LNW-1:0]   lane;
    logic [HDW-1:0]   data;
    logic [HDW/8-1:0] sel;
  } req_t;

endpackage

// File: rtl/dram_wb_line_buffer.sv
// Single-line read buffer: storage, tag compare and write-through byte merge.
// Instantiated by the adapter only when DRAM_WB_LINE_BUFFER_EN is defined.
module dram_wb_line_buffer
  import dram_wb_pkg::*;
#(
  parameter int DW = DDW,
  parameter int AW = DAW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fill_i,
  input  logic          merge_i,
  input  logic          inval_i,
  input  logic [AW-1:0] wr_line_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic [DW-1:0] merge_data_i,
  input  logic [DW/8-1:0] merge_sel_i,
  input  logic [AW-1:0] look_line_i,
  output logic          hit_o,
  output logic [DW-1:0] line_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    unique case (1'b1)
      inval_i: valid_d = 1'b0;
      fill_i: begin
        valid_d = 1'b1;
        tag_d   = wr_line_i;
        data_d  = fill_data_i;
      end
      merge_i: begin
        if (valid_q && (tag_q == wr_line_i)) begin
          for (int b = 0; b < DW / 8; b++) begin
            if (merge_sel_i[b]) data_d[b*8 +: 8] = merge_data_i[b*8 +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (tag_q == look_line_i);
  assign line_o = data_q;

endmodule

// File: rtl/dram_wb_adapter.sv
// Narrow host Wishbone to 256-bit LiteDRAM user port, with err/timeout.
// Define DRAM_WB_LINE_BUFFER_EN to serve repeated line reads from a buffer.
module dram_wb_adapter
  import dram_wb_pkg::*;
#(
  parameter int HOST_DATA_WIDTH = HDW,
  parameter int DRAM_DATA_WIDTH = DDW,
  parameter int DRAM_ADDR_WIDTH = DAW,
  parameter int HOST_ADDR_WIDTH = HAW,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         user_clk,
  input  logic                         user_rst,
  input  logic                         initialized,
  input  logic                         cyc_i,
  input  logic                         stb_i,
  input  logic                         we_i,
  input  logic [HOST_ADDR_WIDTH-1:0]   addr_i,
  input  logic [HOST_DATA_WIDTH-1:0]   data_i,
  input  logic [HOST_DATA_WIDTH/8-1:0] sel_i,
  output logic [HOST_DATA_WIDTH-1:0]   data_o,
  output logic                         ack_o,
  output logic                         err_o,
  output logic                         dram_cyc_o,
  output logic                         dram_stb_o,
  output logic                         dram_we_o,
  output logic [DRAM_ADDR_WIDTH-1:0]   dram_adr_o,
  output logic [DRAM_DATA_WIDTH-1:0]   dram_dat_w_o,
  output logic [DRAM_DATA_WIDTH/8-1:0] dram_sel_o,
  input  logic [DRAM_DATA_WIDTH-1:0]   dram_dat_r_i,
  input  logic                         dram_ack_i,
  input  logic                         dram_err_i,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int OFS   = ofs_w(DRAM_DATA_WIDTH);
  localparam int LSB   = lsb_w(HOST_DATA_WIDTH);
  localparam int LANES = DRAM_DATA_WIDTH / HOST_DATA_WIDTH;
  localparam int HSW   = HOST_DATA_WIDTH / 8;
  localparam int CW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e                     st_q, st_d;
  req_t                       req_q, req_d;
  logic [CW-1:0]              wait_q, wait_d;
  logic [HOST_DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                       err_q, err_d;
  logic                       to_q, to_d;

  logic fill, merge, inval, hit;
  logic in_req, req_v;
  logic [DRAM_ADDR_WIDTH-1:0] line_in;
  logic [LNW-1:0]             lane_in;

  logic [LANES-1:0][HOST_DATA_WIDTH-1:0] rd_lanes, buf_lanes;
  logic [LANES-1:0][HSW-1:0]             wsel;

  logic unused_addr;

  assign req_v    = cyc_i & stb_i & initialized;
  assign line_in  = addr_i[OFS +: DRAM_ADDR_WIDTH];
  assign lane_in  = addr_i[OFS-1:LSB];
  assign rd_lanes = dram_dat_r_i;

  assign unused_addr = ^{addr_i[HOST_ADDR_WIDTH-1:OFS+DRAM_ADDR_WIDTH],
                         addr_i[LSB-1:0]};

`ifdef DRAM_WB_LINE_BUFFER_EN
  logic [DRAM_DATA_WIDTH-1:0] buf_line;

  dram_wb_line_buffer #(
    .DW(DRAM_DATA_WIDTH),
    .AW(DRAM_ADDR_WIDTH)
  ) u_buf (
    .clk_i       (user_clk),
    .rst_i       (user_rst),
    .fill_i      (fill),
    .merge_i     (merge),
    .inval_i     (inval),
    .wr_line_i   (req_q.line),
    .fill_data_i (dram_dat_r_i),
    .merge_data_i(dram_dat_w_o),
    .merge_sel_i (dram_sel_o),
    .look_line_i (line_in),
    .hit_o       (hit),
    .line_o      (buf_line)
  );

  assign buf_lanes = buf_line;
`else
  logic unused_buf;

  assign unused_buf = fill ^ merge ^ inval;
  assign hit        = 1'b0;
  assign buf_lanes  = '0;
`endif

  always_comb begin
    st_d   = st_q;
    req_d  = req_q;
    wait_d = '0;
    rdat_d = rdat_q;
    err_d  = err_q;
    to_d   = to_q;
    fill   = 1'b0;
    merge  = 1'b0;
    inval  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (req_v) begin
          req_d.we   = we_i;
          req_d.line = line_in;
          req_d.lane = lane_in;
          req_d.data = data_i;
          req_d.sel  = sel_i;
          if (!we_i && hit) begin
            st_d   = ST_RESP;
            rdat_d = buf_lanes[lane_in];
            err_d  = 1'b0;
            to_d   = 1'b0;
          end else begin
            st_d = ST_DRAM_REQ;
          end
        end
      end
      ST_DRAM_REQ: begin
        wait_d = wait_q + 1'b1;
        // err outranks ack, ack outranks the timeout
        if (dram_err_i) begin
          st_d  = ST_RESP;
          err_d = 1'b1;
          to_d  = 1'b0;
          inval = 1'b1;
        end else if (dram_ack_i) begin
          st_d   = ST_RESP;
          err_d  = 1'b0;
          to_d   = 1'b0;
          rdat_d = rd_lanes[req_q.lane];
          fill   = ~req_q.we;
          merge  = req_q.we;
        end else if (wait_q == WAIT_LAST) begin
          st_d  = ST_RESP;
          err_d = 1'b1;
          to_d  = 1'b1;
          inval = 1'b1;
        end
      end
      ST_RESP: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      st_q   <= ST_IDLE;
      req_q  <= '0;
      wait_q <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      req_q  <= req_d;
      wait_q <= wait_d;
      rdat_q <= rdat_d;
      err_q  <= err_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    wsel             = '0;
    wsel[req_q.lane] = req_q.sel;
  end

  assign in_req       = (st_q == ST_DRAM_REQ);
  assign dram_cyc_o   = in_req;
  assign dram_stb_o   = in_req;
  assign dram_we_o    = in_req & req_q.we;
  assign dram_adr_o   = in_req ? req_q.line : '0;
  assign dram_dat_w_o = in_req ? {LANES{req_q.data}} : '0;
  assign dram_sel_o   = !in_req  ? '0 :
                        req_q.we ? wsel : '1;

  assign data_o    = rdat_q;
  assign ack_o     = (st_q == ST_RESP) & ~err_q;
  assign err_o     = (st_q == ST_RESP) & err_q;
  assign timeout_o = (st_q == ST_RESP) & to_q;
  assign busy_o    = (st_q != ST_IDLE);

endmodule

// File: tb/tb_dram_wb_adapter.sv
// Randomized scoreboard bench for dram_wb_adapter against a byte-level memory model.
// Buffer expectations follow DRAM_WB_LINE_BUFFER_EN when it is defined.
module tb_dram_wb_adapter;

  localparam int TO = 16;
`ifdef DRAM_WB_LINE_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic         user_clk = 1'b0;
  logic         user_rst;
  logic         initialized;
  logic         cyc_i, stb_i, we_i;
  logic [31:0]  addr_i, data_i;
  logic [3:0]   sel_i;
  logic [31:0]  data_o;
  logic         ack_o, err_o;
  logic         dram_cyc_o, dram_stb_o, dram_we_o;
  logic [24:0]  dram_adr_o;
  logic [255:0] dram_dat_w_o;
  logic [31:0]  dram_sel_o;
  logic [255:0] dram_dat_r_i;
  logic         dram_ack_i, dram_err_i;
  logic         busy_o, timeout_o;

  always #5 user_clk = ~user_clk;

  dram_wb_adapter #(
    .HOST_DATA_WIDTH(32),
    .DRAM_DATA_WIDTH(256),
    .DRAM_ADDR_WIDTH(25),
    .HOST_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .initialized (initialized),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .sel_i       (sel_i),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .dram_cyc_o  (dram_cyc_o),
    .dram_stb_o  (dram_stb_o),
    .dram_we_o   (dram_we_o),
    .dram_adr_o  (dram_adr_o),
    .dram_dat_w_o(dram_dat_w_o),
    .dram_sel_o  (dram_sel_o),
    .dram_dat_r_i(dram_dat_r_i),
    .dram_ack_i  (dram_ack_i),
    .dram_err_i  (dram_err_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    bit          err;
    bit          to;
    bit          hit;
    bit          chk_lat;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   req_cyc, dack_cyc, req_cnt;
  bit   done;
  int   mode;

  logic [24:0]  x_adr;
  logic [31:0]  x_sel;
  logic         x_we;
  logic [255:0] x_datw;

  logic [7:0]   rmem[int];
  logic [255:0] dmem[int];
  bit           bvalid;
  logic [24:0]  btag;

  always @(posedge user_clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 7) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return rmem.exists(a) ? rmem[a] : init_byte(a);
  endfunction

  function automatic logic [255:0] dline(input int line);
    logic [255:0] l;
    if (dmem.exists(line)) return dmem[line];
    for (int b = 0; b < 32; b++) l[b*8 +: 8] = init_byte(line * 32 + b);
    return l;
  endfunction

  task automatic check(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // DRAM responder: random latency, mode selects ack / err / ack+err / silence
  initial begin
    bit prev = 1'b0;
    int cd = 0;
    int ln;
    logic [255:0] l;
    forever begin
      @(negedge user_clk);
      dram_ack_i = 1'b0;
      dram_err_i = 1'b0;
      for (int k = 0; k < 8; k++) dram_dat_r_i[k*32 +: 32] = $urandom;
      if (dram_cyc_o && dram_stb_o) begin
        if (!prev) begin
          req_cnt++;
          check("dram_adr", dram_adr_o, x_adr);
          check("dram_we", dram_we_o, x_we);
          check("dram_sel", dram_sel_o, x_sel);
          if (x_we) check("dram_dat_w", dram_dat_w_o, x_datw);
          cd = $urandom_range(0, 3);
        end
        if (mode != 3) begin
          if (cd == 0) begin
            dack_cyc = cyc + 1;
            ln = int'(dram_adr_o);
            l = dline(ln);
            if (mode == 0 && dram_we_o) begin
              for (int b = 0; b < 32; b++)
                if (dram_sel_o[b]) l[b*8 +: 8] = dram_dat_w_o[b*8 +: 8];
              dmem[ln] = l;
            end
            if (mode != 1) dram_ack_i = 1'b1;
            if (mode != 0) dram_err_i = 1'b1;
            dram_dat_r_i = l;
          end else begin
            cd--;
          end
        end
      end
      prev = dram_cyc_o && dram_stb_o;
    end
  end

  // Monitor: pop one expectation per host termination
  initial begin
    exp_t e;
    forever begin
      @(negedge user_clk);
      if (ack_o || err_o || timeout_o) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got ack=%0b err=%0b to=%0b want none",
                   ack_o, err_o, timeout_o);
        end else begin
          e = expq.pop_front();
          check("err_o", err_o, e.err);
          check("ack_o", ack_o, !e.err);
          check("timeout_o", timeout_o, e.to);
          if (e.is_rd && !e.err) check("data_o", data_o, e.data);
          if (e.err) check("dram_cyc_dropped", dram_cyc_o, 1'b0);
          check("dram_reqs", req_cnt, e.hit ? 0 : 1);
          if (e.chk_lat) begin
            if (e.hit) check("lat_hit", cyc, req_cyc);
            else if (e.to) check("lat_timeout", cyc, req_cyc + TO);
            else check("lat_miss", cyc, dack_cyc);
          end
          done = 1'b1;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int m, input bit lat);
    exp_t e;
    int   ba;
    ba = int'(a[29:2]) << 2;
    e = '{default: 0};
    e.chk_lat = lat;
    e.is_rd   = !we;
    e.hit     = BUF_EN && !we && bvalid && (btag == a[29:5]);
    if (!e.hit && m != 0) begin
      e.err  = 1'b1;
      e.to   = (m == 3);
      bvalid = 1'b0;
    end else if (we) begin
      for (int k = 0; k < 4; k++) if (s[k]) rmem[ba + k] = d[k*8 +: 8];
    end else begin
      for (int k = 0; k < 4; k++) e.data[k*8 +: 8] = ref_rd(ba + k);
      if (BUF_EN) begin
        bvalid = 1'b1;
        btag   = a[29:5];
      end
    end
    expq.push_back(e);
    x_adr  = a[29:5];
    x_we   = we;
    x_sel  = we ? (32'(s) << (4 * a[4:2])) : '1;
    x_datw = {8{d}};
    @(negedge user_clk);
    mode     = m;
    req_cnt  = 0;
    done     = 1'b0;
    dack_cyc = -100;
    cyc_i    = 1'b1;
    stb_i    = 1'b1;
    we_i     = we;
    addr_i   = a;
    data_i   = d;
    sel_i    = s;
    req_cyc  = cyc + 1;
  endtask

  task automatic complete();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge user_clk);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL no_response: got none want ack/err within 100 cycles");
      expq.delete();
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    @(negedge user_clk);
    #1;
    check("pulse_one_cycle", {ack_o, err_o}, 2'b00);
  endtask

  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int m);
    issue(we, a, d, s, m, 1'b1);
    complete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, m;
    logic [31:0] a;
    user_rst = 1'b1;
    initialized = 1'b1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    addr_i = '0; data_i = '0; sel_i = '0;
    mode = 0; req_cnt = 0; done = 1'b0;
    bvalid = 1'b0; btag = '0;
    x_adr = '0; x_sel = '0; x_we = 1'b0; x_datw = '0;
    repeat (3) @(negedge user_clk);
    check("rst_outputs", {ack_o, err_o, busy_o, timeout_o, dram_cyc_o,
                          dram_stb_o, dram_we_o, dram_adr_o, dram_sel_o, data_o}, '0);
    user_rst = 1'b0;
    @(negedge user_clk);
    #1;
    check("idle_after_rst", {busy_o, dram_stb_o, dram_dat_w_o}, '0);

    xact(1'b1, 32'h0000_0024, 32'hA5A5_1234, 4'b0011, 0);
    xact(1'b1, 32'h0000_003C, 32'hDEAD_BEEF, 4'b1111, 0);
    xact(1'b0, 32'h0000_003C, 32'h0, 4'b1111, 0);
    xact(1'b0, 32'h0000_0100, 32'h0, 4'b1111, 3);
    xact(1'b0, 32'h0000_0024, 32'h0, 4'b1111, 0);
    xact(1'b0, 32'h0000_0120, 32'h0, 4'b1111, 2);
    xact(1'b0, 32'h0000_0140, 32'h0, 4'b1111, 1);
    xact(1'b0, 32'h0000_0040, 32'h0, 4'b1111, 0);
    xact(1'b0, 32'h0000_0044, 32'h0, 4'b1111, 0);
    xact(1'b1, 32'h0000_0044, 32'h1357_9BDF, 4'b1111, 0);
    xact(1'b0, 32'h0000_0044, 32'h0, 4'b1111, 0);
    xact(1'b1, 32'hC000_0046, 32'h00AB_0000, 4'b0100, 0);
    xact(1'b0, 32'h0000_0044, 32'h0, 4'b1111, 0);

    // reset while the DRAM request is outstanding
    @(negedge user_clk);
    mode = 3; req_cnt = 0;
    x_adr = 25'h4; x_we = 1'b0; x_sel = '1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 32'h84;
    repeat (3) @(negedge user_clk);
    #1;
    check("stb_before_rst", dram_stb_o, 1'b1);
    user_rst = 1'b1;
    #1;
    check("outputs_in_rst", {ack_o, err_o, busy_o, timeout_o, dram_cyc_o,
                             dram_stb_o, dram_we_o, dram_adr_o, dram_sel_o, data_o}, '0);
    check("dat_w_in_rst", dram_dat_w_o, '0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge user_clk);
    user_rst = 1'b0;
    bvalid = 1'b0;
    xact(1'b0, 32'h0000_0044, 32'h0, 4'b1111, 0);

    // requests wait while the DRAM is not initialized
    initialized = 1'b0;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'b1111, 0, 1'b0);
    repeat (5) @(negedge user_clk);
    #1;
    check("stall_busy", busy_o, 1'b0);
    check("stall_no_resp", done, 1'b0);
    initialized = 1'b1;
    complete();

    for (int i = 0; i < 60; i++) begin
      a = {2'($urandom_range(0, 3)), 25'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 19);
      m = (r < 14) ? 0 : (r < 17) ? 1 : (r < 19) ? 2 : 3;
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)), m);
    end

    check("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_wb_adapter.md
# dram_wb_adapter

Single-clock Wishbone width adapter between a narrow host bus and the 256-bit LiteDRAM user Wishbone port, in the `user_clk` domain behind the clock-crossing FIFOs. It maps byte addresses to DRAM lines, steers data and byte-selects into the correct lane, and adds bus-error and timeout reporting. An optional single-line read buffer serves repeated reads to the same DRAM line without a DRAM transaction.

## Interface
- `HOST_DATA_WIDTH`, 32: host data width; power of two, ≥8, divides `DRAM_DATA_WIDTH`.
- `DRAM_DATA_WIDTH`, 256: DRAM user-port data width.
- `DRAM_ADDR_WIDTH`, 25: DRAM line-address width.
- `HOST_ADDR_WIDTH`, 32: host byte-address width.
- `TIMEOUT_CYCLES`, 1024: maximum DRAM wait, in cycles, before abort; ≥2.

Single clock `user_clk`; reset `user_rst` is asynchronous and active-high.

- `user_clk` in 1: clock.
- `user_rst` in 1: async active-high reset.
- `initialized` in 1: DRAM ready; no request is accepted while low.
- `cyc_i`, `stb_i`, `we_i` in 1: host Wishbone classic controls.
- `addr_i` in `HOST_ADDR_WIDTH`: host byte address.
- `data_i` in `HOST_DATA_WIDTH`: write data.
- `sel_i` in `HOST_DATA_WIDTH/8`: byte selects.
- `data_o` out `HOST_DATA_WIDTH`: read data, valid with `ack_o`.
- `ack_o`, `err_o` out 1: one-cycle termination pulses.
- `dram_cyc_o`, `dram_stb_o`, `dram_we_o` out 1: DRAM port controls.
- `dram_adr_o` out `DRAM_ADDR_WIDTH`: line address.
- `dram_dat_w_o` out `DRAM_DATA_WIDTH`: write data.
- `dram_sel_o` out `DRAM_DATA_WIDTH/8`: byte selects.
- `dram_dat_r_i` in `DRAM_DATA_WIDTH`: read data.
- `dram_ack_i`, `dram_err_i` in 1: DRAM termination.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `timeout_o` out 1: one-cycle pulse when a DRAM access is aborted.

## Operation
- `OFS = $clog2(DRAM_DATA_WIDTH/8)` and `LSB = $clog2(HOST_DATA_WIDTH/8)`.
- Line address is `addr_i[OFS +: DRAM_ADDR_WIDTH]`; upper bits are ignored. Lane index is `addr_i[OFS-1:LSB]`.
- Writes:
  - `dram_dat_w_o` is `data_i` replicated in every lane.
  - `dram_sel_o` is `sel_i` placed at the lane index, with zeros elsewhere.
- Reads: `dram_sel_o` is all ones; `data_o` is the indexed lane of `dram_dat_r_i`.
- FSM states are IDLE, DRAM_REQ and RESP.
  - IDLE → DRAM_REQ when `cyc_i & stb_i & initialized` (buffer miss or write). Request fields are registered on entry.
  - DRAM_REQ asserts `dram_cyc_o`/`dram_stb_o` and holds all DRAM outputs stable.
    - On `dram_ack_i`: register the lane into `data_o`, drop the DRAM controls, go to RESP with ack.
    - On `dram_err_i`: drop the DRAM controls, go to RESP with err.
    - Timeout: the wait counter reaches `TIMEOUT_CYCLES-1` with no ack or err. Drop the DRAM controls, pulse `timeout_o`, go to RESP with err.
  - RESP pulses `ack_o` or `err_o` for one cycle, then returns to IDLE.
- Priority within a cycle: `dram_err_i` beats `dram_ack_i`, and `dram_ack_i` beats timeout.
- `stb_i` still high in the cycle after RESP is treated as a new request (back-to-back).
- Reset (async, including mid-transaction):
  - All outputs go to 0, the FSM goes to IDLE, and the wait counter clears.
  - The buffer is invalidated; any in-flight DRAM cycle is abandoned.

## Timing
- Miss or write:
  - Request sampled in cycle 0; `dram_stb_o` goes high in cycle 1.
  - `dram_ack_i` sampled in cycle N; `ack_o` goes high in cycle N+1.
- Buffer hit: request sampled in cycle 0; `ack_o` goes high in cycle 1; no DRAM activity.
- Minimum miss latency is 2 cycles, given `dram_ack_i` in cycle 1.
- Timeout: `err_o` rises `TIMEOUT_CYCLES+1` cycles after the request is sampled.
- While `initialized` is low, requests stay pending, with no ack and no err.

## Configuration
- `DRAM_WB_LINE_BUFFER_EN` defined:
  - Holds one line, a `DRAM_ADDR_WIDTH` tag and a valid bit.
  - Filled on every successful DRAM read.
  - A read with valid set and a tag match is a hit and goes IDLE → RESP.
  - A write whose tag matches merges the selected bytes into the buffer in the same cycle as `dram_ack_i` (write-through).
  - Any err or timeout invalidates the buffer.
- Not defined: no buffer storage; every access goes to DRAM.

## Structure
- Package `dram_wb_pkg`:
  - FSM state enum.
  - Registered request struct: `we`, line address, lane index, data, sel.
  - Lane/offset width helper functions.
- Sub-module `dram_wb_line_buffer`, instantiated only under the macro: storage, tag compare, byte-merge.

## Test plan
- 32-bit write, `addr_i=0x0000_0024`, `sel_i=4'b0011` → `dram_adr_o=1`, `dram_sel_o=32'h0000_0030`; `ack_o` one cycle after `dram_ack_i`.
- Read `addr_i=0x3C`, `dram_dat_r_i` lane 7 = `0xDEADBEEF` → `data_o=0xDEADBEEF`, `dram_sel_o` all ones.
- `TIMEOUT_CYCLES=16`, DRAM never acks → `timeout_o` pulse, `err_o` at cycle 17, `dram_cyc_o` low, next request accepted.
- `dram_ack_i` and `dram_err_i` asserted together → `err_o=1`, `ack_o=0`.
- With the macro defined:
  - Read 0x40, then read 0x44 → second access acks in 1 cycle with no `dram_stb_o`.
  - Write 0x44, then read it back → returns the new data.
- `user_rst` raised in DRAM_REQ → all outputs 0 immediately; after release, read 0x44 goes to DRAM (buffer invalid).
